// File: rtl/bcd_disp_pkg.sv
// Shared types and seven-segment patterns for the BCD display multiplexer.
// All patterns are active-high, bit order g..a (bit 6 = g, bit 0 = a).
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0    = 7'b0111111;
  localparam seg7_t SEG_1    = 7'b0000110;
  localparam seg7_t SEG_2    = 7'b1011011;
  localparam seg7_t SEG_3    = 7'b1001111;
  localparam seg7_t SEG_4    = 7'b1100110;
  localparam seg7_t SEG_5    = 7'b1101101;
  localparam seg7_t SEG_6    = 7'b1111101;
  localparam seg7_t SEG_7    = 7'b0000111;
  localparam seg7_t SEG_8    = 7'b1111111;
  localparam seg7_t SEG_9    = 7'b1101111;
  localparam seg7_t SEG_DASH = 7'b1000000;
  localparam seg7_t SEG_OFF  = 7'b0000000;

  // Active-high one-hot digit enable: an[0] = units, an[1] = tens.
  function automatic logic [1:0] an_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// Digit-load and display-pin bundle for bcd_display_mux.
// master: the BCD producer / observer side; slave: the display multiplexer.
interface bcd_display_mux_if;
  import bcd_disp_pkg::*;

  logic       load;
  bcd_digit_t tens;
  bcd_digit_t units;
  seg7_t      seg;
  logic [1:0] an;
  logic       frame;

  modport master (
    output load,
    output tens,
    output units,
    input  seg,
    input  an,
    input  frame
  );

  modport slave (
    input  load,
    input  tens,
    input  units,
    output seg,
    output an,
    output frame
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high g..a.
// Codes 10..15 are not valid BCD and show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  bcd_digit_t i_digit,
  output seg7_t      o_seg
);

  // Digit pattern lookup with dash for invalid codes.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit time-multiplexed seven-segment driver.
// A loaded digit pair is held pending and only copied to the displayed shadow
// registers at a frame boundary (end of the tens phase), so a frame never mixes
// old and new digits.
// Optional build macro BCD_DISPLAY_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  bcd_display_mux_if.slave   bus
);

  localparam int unsigned     DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  // XOR masks that turn active-high patterns into pin levels.
  localparam seg7_t           SegPol = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]      AnPol  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [DivW-1:0] r_div;
  logic            r_sel;
  bcd_digit_t      r_pend_tens;
  bcd_digit_t      r_pend_units;
  logic            r_pend_valid;
  bcd_digit_t      r_sh_tens;
  bcd_digit_t      r_sh_units;
  seg7_t           r_seg;
  logic [1:0]      r_an;
  logic            r_frame;

  logic            w_tick;
  logic            w_boundary;
  bcd_digit_t      w_digit;
  seg7_t           w_seg_dec;
  seg7_t           w_seg_hi;

  assign w_tick     = (r_div == DivMax);
  // Boundary is the tens-to-units transition.
  assign w_boundary = w_tick & r_sel;
  assign w_digit    = r_sel ? r_sh_tens : r_sh_units;

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  // Blank or pass the decoded pattern for the selected digit.
  always_comb begin
    w_seg_hi = w_seg_dec;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    if (r_sel && (r_sh_tens == 4'd0)) begin
      w_seg_hi = SEG_OFF;
    end
`else
    w_seg_hi = w_seg_dec;
`endif
  end

  // Refresh divider and digit select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_sel <= 1'b0;
    end else if (w_tick) begin
      r_div <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  // Pending capture and boundary-aligned shadow update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_tens  <= '0;
      r_pend_units <= '0;
      r_pend_valid <= 1'b0;
      r_sh_tens    <= '0;
      r_sh_units   <= '0;
    end else if (w_boundary) begin
      // A load on the boundary bypasses pending and goes straight to the shadow.
      if (bus.load) begin
        r_pend_tens  <= bus.tens;
        r_pend_units <= bus.units;
        r_sh_tens    <= bus.tens;
        r_sh_units   <= bus.units;
      end else if (r_pend_valid) begin
        r_sh_tens    <= r_pend_tens;
        r_sh_units   <= r_pend_units;
      end
      r_pend_valid <= 1'b0;
    end else if (bus.load) begin
      r_pend_tens  <= bus.tens;
      r_pend_units <= bus.units;
      r_pend_valid <= 1'b1;
    end
  end

  // Registered pin stage with polarity applied last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg   <= SegPol ^ SEG_OFF;
      r_an    <= AnPol;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= SegPol ^ w_seg_hi;
      r_an    <= AnPol ^ an_onehot(r_sel);
      r_frame <= w_boundary;
    end
  end

  assign bus.seg   = r_seg;
  assign bus.an    = r_an;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with CLK_DIV=4, active-low outputs.
// Edge k is the k-th rising clock edge; outputs are sampled on the falling
// edge after it (noted Nk). Boundaries fall on edges 11, 19, 27, ... until reset.
module tb_bcd_display_mux;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  bcd_display_mux_if bus ();

  bcd_display_mux #(
    .CLK_DIV        (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] P0    = ~7'b0111111;
  localparam logic [6:0] P1    = ~7'b0000110;
  localparam logic [6:0] P2    = ~7'b1011011;
  localparam logic [6:0] P3    = ~7'b1001111;
  localparam logic [6:0] P4    = ~7'b1100110;
  localparam logic [6:0] P5    = ~7'b1101101;
  localparam logic [6:0] P7    = ~7'b0000111;
  localparam logic [6:0] P8    = ~7'b1111111;
  localparam logic [6:0] PDASH = ~7'b1000000;
  localparam logic [6:0] POFF  = 7'h7F;
`ifdef BCD_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] PT0   = POFF;
`else
  localparam logic [6:0] PT0   = P0;
`endif
  localparam logic [1:0] AN_U  = 2'b10;
  localparam logic [1:0] AN_T  = 2'b01;
  localparam logic [1:0] AN_X  = 2'b11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] es, input logic [1:0] ea);
    n_chk++;
    assert (bus.seg === es) else begin
      n_err++;
      $error("FAIL %s.seg: got %b want %b", tag, bus.seg, es);
    end
    n_chk++;
    assert (bus.an === ea) else begin
      n_err++;
      $error("FAIL %s.an: got %b want %b", tag, bus.an, ea);
    end
  endtask

  task automatic chk_frame(input string tag, input logic ef);
    n_chk++;
    assert (bus.frame === ef) else begin
      n_err++;
      $error("FAIL %s.frame: got %b want %b", tag, bus.frame, ef);
    end
  endtask

  task automatic chk_pend(input string tag, input logic ep);
    n_chk++;
    assert (dut.r_pend_valid === ep) else begin
      n_err++;
      $error("FAIL %s.pend_valid: got %b want %b", tag, dut.r_pend_valid, ep);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] t, input logic [3:0] u);
    bus.load  = ld;
    bus.tens  = t;
    bus.units = u;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0);

    // Reset held over edges 1..3.
    go(3);                                   // N3
    chk_disp("reset", POFF, AN_X);
    chk_frame("reset", 1'b0);
    rst_n = 1'b1;
    go(1);                                   // N4
    chk_disp("first_units", P0, AN_U);
    chk_frame("first_units", 1'b0);

    // Mid-frame load 1/5, applied at boundary edge 11.
    go(1);                                   // N5
    drive(1'b1, 4'd1, 4'd5);
    chk_frame("pre_bnd_5", 1'b0);
    go(1);                                   // N6
    drive(1'b0, 4'd0, 4'd0);
    chk_disp("units_unchanged", P0, AN_U);
    chk_pend("after_load15", 1'b1);
    go(2);                                   // N8
    chk_disp("tens_unchanged", PT0, AN_T);
    chk_frame("pre_bnd_8", 1'b0);
    go(3);                                   // N11
    chk_frame("bnd11", 1'b1);
    chk_disp("tens_at_bnd", PT0, AN_T);
    go(1);                                   // N12
    chk_frame("post_bnd12", 1'b0);
    chk_disp("units_5", P5, AN_U);
    chk_pend("after_bnd11", 1'b0);
    go(4);                                   // N16
    chk_disp("tens_1", P1, AN_T);
    go(2);                                   // N18
    chk_frame("pre_bnd18", 1'b0);
    go(1);                                   // N19
    chk_frame("bnd19", 1'b1);
    go(1);                                   // N20
    chk_frame("post_bnd20", 1'b0);
    chk_disp("units_5_again", P5, AN_U);

    // Load 4/2 sampled exactly on boundary edge 27.
    go(6);                                   // N26
    drive(1'b1, 4'd4, 4'd2);
    go(1);                                   // N27
    drive(1'b0, 4'd0, 4'd0);
    chk_frame("bnd27", 1'b1);
    go(1);                                   // N28
    chk_disp("coinc_units_2", P2, AN_U);
    chk_pend("coinc_clear", 1'b0);

    // Overwrite: 3/3 then 7/8 before boundary edge 35.
    go(1);                                   // N29
    drive(1'b1, 4'd3, 4'd3);
    go(1);                                   // N30
    drive(1'b1, 4'd7, 4'd8);
    go(1);                                   // N31
    drive(1'b0, 4'd0, 4'd0);
    chk_pend("ovw_pending", 1'b1);
    go(1);                                   // N32
    chk_disp("coinc_tens_4", P4, AN_T);
    go(3);                                   // N35
    chk_disp("ovw_tens_hold", P4, AN_T);
    chk_frame("bnd35", 1'b1);
    go(1);                                   // N36
    chk_disp("ovw_units_8", P8, AN_U);
    n_chk++;
    assert (bus.seg !== P3) else begin
      n_err++;
      $error("FAIL ovw_no3: got %b want not %b", bus.seg, P3);
    end
    go(4);                                   // N40
    chk_disp("ovw_tens_7", P7, AN_T);

    // Invalid BCD C/F, boundary edge 43.
    go(1);                                   // N41
    drive(1'b1, 4'hC, 4'hF);
    go(1);                                   // N42
    drive(1'b0, 4'd0, 4'd0);
    go(2);                                   // N44
    chk_disp("dash_units", PDASH, AN_U);
    go(4);                                   // N48
    chk_disp("dash_tens", PDASH, AN_T);

    // Pending 9/9 discarded by reset over edges 51..52.
    go(1);                                   // N49
    drive(1'b1, 4'd9, 4'd9);
    go(1);                                   // N50
    drive(1'b0, 4'd0, 4'd0);
    rst_n = 1'b0;
    go(1);                                   // N51
    chk_disp("midreset", POFF, AN_X);
    chk_frame("midreset", 1'b0);
    chk_pend("midreset", 1'b0);
    go(1);                                   // N52
    rst_n = 1'b1;
    go(1);                                   // N53
    chk_disp("rst_units_0", P0, AN_U);
    go(4);                                   // N57
    chk_disp("rst_tens_0", PT0, AN_T);
    go(3);                                   // N60
    chk_frame("bnd60", 1'b1);
    go(1);                                   // N61
    chk_disp("lost_99", P0, AN_U);

    // Load 0/7, boundary edge 68; tens zero shows per build option.
    go(1);                                   // N62
    drive(1'b1, 4'd0, 4'd7);
    go(1);                                   // N63
    drive(1'b0, 4'd0, 4'd0);
    go(6);                                   // N69
    chk_disp("lz_units_7", P7, AN_U);
    go(4);                                   // N73
    chk_disp("lz_tens", PT0, AN_T);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
